// File: rtl/pipe_dest_tracker.sv
// Destination/write-enable/load tracking for the EXU, MEM and WB stages of the
// RV32I pipeline, with load-use bubble insertion, redirect flush and ext stall.
module pipe_dest_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        IDU_valid,
  input  logic [4:0]  IDU_rs1,
  input  logic [4:0]  IDU_rs2,
  input  logic        IDU_uses_rs1,
  input  logic        IDU_uses_rs2,
  input  logic [4:0]  IDU_rd,
  input  logic        IDU_R_Wen,
  input  logic        IDU_mem_ren,
  input  logic        EXU_redirect,
  input  logic        ext_stall,
  output logic [4:0]  EXU_rd,
  output logic [4:0]  MEM_rd,
  output logic [4:0]  WB_rd,
  output logic        EXU_valid,
  output logic        MEM_valid,
  output logic        WB_valid,
  output logic        EXU_R_Wen,
  output logic        MEM_R_Wen,
  output logic        WB_R_Wen,
  output logic        EXU_mem_ren,
  output logic        MEM_mem_ren,
  output logic        load_use_stall,
  output logic        IDU_hold,
  output logic        IDU_kill,
  output logic [31:0] retire_cnt,
  output logic [31:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       mem_ren;
  } stage_t;

  stage_t exu_q, mem_q, wb_q, idu_s;
  logic   lu, redir;

  assign idu_s = '{valid: IDU_valid, rd: IDU_rd, wen: IDU_R_Wen, mem_ren: IDU_mem_ren};

  // Only a load that actually writes a non-zero register can cause a hazard.
  assign lu = exu_q.valid & exu_q.mem_ren & exu_q.wen & (exu_q.rd != 5'd0) & IDU_valid &
              ((IDU_uses_rs1 & (IDU_rs1 == exu_q.rd)) |
               (IDU_uses_rs2 & (IDU_rs2 == exu_q.rd)));
  assign redir = EXU_redirect & exu_q.valid;

  // IDU_hold asks IDU/IF to keep their contents; IDU_kill discards the IDU
  // instruction. ext_stall outranks redirect, which outranks load-use.
  always_comb begin
    load_use_stall = 1'b0;
    IDU_hold       = 1'b0;
    IDU_kill       = 1'b0;
    if (ext_stall) begin
      IDU_hold = 1'b1;
    end else if (redir) begin
      IDU_kill = 1'b1;
    end else if (lu) begin
      load_use_stall = 1'b1;
      IDU_hold       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exu_q      <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (!ext_stall) begin
        wb_q  <= mem_q;
        mem_q <= exu_q;
        exu_q <= (redir || lu) ? stage_t'('0) : idu_s;
      end
      if (wb_q.valid && !ext_stall)
        retire_cnt <= retire_cnt + 32'd1;
      if (ext_stall || load_use_stall)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign EXU_rd      = exu_q.rd;
  assign MEM_rd      = mem_q.rd;
  assign WB_rd       = wb_q.rd;
  assign EXU_valid   = exu_q.valid;
  assign MEM_valid   = mem_q.valid;
  assign WB_valid    = wb_q.valid;
  assign EXU_R_Wen   = exu_q.wen & exu_q.valid;
  assign MEM_R_Wen   = mem_q.wen & mem_q.valid;
  assign WB_R_Wen    = wb_q.wen & wb_q.valid;
  assign EXU_mem_ren = exu_q.mem_ren & exu_q.valid;
  assign MEM_mem_ren = mem_q.mem_ren & mem_q.valid;

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Directed bench for pipe_dest_tracker: latency, load-use, false hazards,
// redirect, ext_stall freeze, async reset and retire counter wrap.
module tb_pipe_dest_tracker;

  logic        clk, rst;
  logic        IDU_valid, IDU_uses_rs1, IDU_uses_rs2, IDU_R_Wen, IDU_mem_ren;
  logic [4:0]  IDU_rs1, IDU_rs2, IDU_rd;
  logic        EXU_redirect, ext_stall;
  logic [4:0]  EXU_rd, MEM_rd, WB_rd;
  logic        EXU_valid, MEM_valid, WB_valid;
  logic        EXU_R_Wen, MEM_R_Wen, WB_R_Wen, EXU_mem_ren, MEM_mem_ren;
  logic        load_use_stall, IDU_hold, IDU_kill;
  logic [31:0] retire_cnt, stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_dest_tracker dut (
    .clk(clk), .rst(rst),
    .IDU_valid(IDU_valid), .IDU_rs1(IDU_rs1), .IDU_rs2(IDU_rs2),
    .IDU_uses_rs1(IDU_uses_rs1), .IDU_uses_rs2(IDU_uses_rs2),
    .IDU_rd(IDU_rd), .IDU_R_Wen(IDU_R_Wen), .IDU_mem_ren(IDU_mem_ren),
    .EXU_redirect(EXU_redirect), .ext_stall(ext_stall),
    .EXU_rd(EXU_rd), .MEM_rd(MEM_rd), .WB_rd(WB_rd),
    .EXU_valid(EXU_valid), .MEM_valid(MEM_valid), .WB_valid(WB_valid),
    .EXU_R_Wen(EXU_R_Wen), .MEM_R_Wen(MEM_R_Wen), .WB_R_Wen(WB_R_Wen),
    .EXU_mem_ren(EXU_mem_ren), .MEM_mem_ren(MEM_mem_ren),
    .load_use_stall(load_use_stall), .IDU_hold(IDU_hold), .IDU_kill(IDU_kill),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic wen, input logic ren,
                       input logic u1, input logic [4:0] rs1, input logic u2, input logic [4:0] rs2);
    IDU_valid = v; IDU_rd = rd; IDU_R_Wen = wen; IDU_mem_ren = ren;
    IDU_uses_rs1 = u1; IDU_rs1 = rs1; IDU_uses_rs2 = u2; IDU_rs2 = rs2;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic drain();
    idle();
    repeat (4) step();
  endtask

  initial begin
    rst = 1'b1; EXU_redirect = 1'b0; ext_stall = 1'b0;
    idle();
    repeat (2) step();
    check("reset_stage_flags",
          {23'd0, EXU_valid, MEM_valid, WB_valid, EXU_R_Wen, MEM_R_Wen, WB_R_Wen,
           EXU_mem_ren, MEM_mem_ren}, 32'd0);
    check("reset_rds", {17'd0, EXU_rd, MEM_rd, WB_rd}, 32'd0);
    check("reset_ctrl", {29'd0, load_use_stall, IDU_hold, IDU_kill}, 32'd0);
    check("reset_retire", retire_cnt, 32'd0);
    check("reset_stall", stall_cnt, 32'd0);
    rst = 1'b0;

    // plain latency: add x3 -> EXU after 1, WB after 3
    drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2);
    check("lat_exu_empty", {31'd0, EXU_valid}, 32'd0);
    step(); idle();
    check("lat_exu", {26'd0, EXU_valid, EXU_rd}, {26'd0, 1'b1, 5'd3});
    check("lat_exu_wen", {31'd0, EXU_R_Wen}, 32'd1);
    step();
    check("lat_mem", {26'd0, MEM_valid, MEM_rd}, {26'd0, 1'b1, 5'd3});
    step();
    check("lat_wb", {25'd0, WB_valid, WB_R_Wen, WB_rd}, {25'd0, 1'b1, 1'b1, 5'd3});
    check("lat_retire_pre", retire_cnt, 32'd0);
    step();
    check("lat_retire", retire_cnt, 32'd1);
    check("lat_wb_gone", {31'd0, WB_valid}, 32'd0);

    // redirect with an empty EXU does nothing
    EXU_redirect = 1'b1; #1;
    check("redir_no_exu", {31'd0, IDU_kill}, 32'd0);
    EXU_redirect = 1'b0;

    // load-use: lw x5 then add x6,x5,x1
    drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0);
    step();
    drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 5'd1);
    check("lu_ctrl", {29'd0, load_use_stall, IDU_hold, IDU_kill}, {29'd0, 3'b110});
    check("lu_exu_ren", {31'd0, EXU_mem_ren}, 32'd1);
    step();
    check("lu_bubble", {31'd0, EXU_valid}, 32'd0);
    check("lu_mem_load", {25'd0, MEM_valid, MEM_mem_ren, MEM_rd}, {25'd0, 1'b1, 1'b1, 5'd5});
    check("lu_one_cycle", {31'd0, load_use_stall}, 32'd0);
    check("lu_stall_cnt", stall_cnt, 32'd1);
    step(); idle();
    check("lu_add_exu", {26'd0, EXU_valid, EXU_rd}, {26'd0, 1'b1, 5'd6});
    drain();
    check("lu_retire", retire_cnt, 32'd3);
    check("lu_stall_cnt_hold", stall_cnt, 32'd1);

    // no false hazards
    drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5);
    check("nofh_unused_src", {30'd0, load_use_stall, IDU_hold}, 32'd0);
    step();
    drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
    check("nofh_not_load", {31'd0, load_use_stall}, 32'd0);
    step();
    drive(1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);
    check("nofh_x0", {30'd0, load_use_stall, IDU_hold}, 32'd0);
    step();
    check("nofh_x0_adv", {26'd0, EXU_valid, EXU_rd}, {26'd0, 1'b1, 5'd10});
    drain();
    check("nofh_retire", retire_cnt, 32'd7);
    check("nofh_stall_cnt", stall_cnt, 32'd1);

    // redirect beats a simultaneous load-use
    drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
    EXU_redirect = 1'b1; #1;
    check("redir_ctrl", {29'd0, load_use_stall, IDU_hold, IDU_kill}, {29'd0, 3'b001});
    step();
    EXU_redirect = 1'b0; idle();
    check("redir_bubble", {31'd0, EXU_valid}, 32'd0);
    check("redir_mem", {26'd0, MEM_valid, MEM_rd}, {26'd0, 1'b1, 5'd5});
    drain();
    check("redir_retire", retire_cnt, 32'd8);
    check("redir_stall_cnt", stall_cnt, 32'd1);

    // ext_stall freezes three in-flight instructions for three cycles
    drive(1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); step();
    drive(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); step();
    drive(1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); step();
    drive(1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    ext_stall = 1'b1; #1;
    check("xs_ctrl", {29'd0, load_use_stall, IDU_hold, IDU_kill}, {29'd0, 3'b010});
    for (int i = 0; i < 3; i++) begin
      step();
      check("xs_frozen_rds", {17'd0, EXU_rd, MEM_rd, WB_rd}, {17'd0, 5'd13, 5'd12, 5'd11});
      check("xs_frozen_valid", {29'd0, EXU_valid, MEM_valid, WB_valid}, {29'd0, 3'b111});
    end
    check("xs_retire", retire_cnt, 32'd8);
    check("xs_stall_cnt", stall_cnt, 32'd4);
    ext_stall = 1'b0; idle();
    step();
    check("xs_resume", {17'd0, EXU_rd, MEM_rd, WB_rd}, {17'd0, 5'd0, 5'd13, 5'd12});
    check("xs_resume_retire", retire_cnt, 32'd9);
    drain();
    check("xs_final_retire", retire_cnt, 32'd11);

    // asynchronous reset mid-stream, then latency from the first IDU_valid
    drive(1'b1, 5'd20, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); step();
    drive(1'b1, 5'd21, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); step();
    idle();
    rst = 1'b1; #1;
    check("arst_stages", {29'd0, EXU_valid, MEM_valid, WB_valid}, 32'd0);
    check("arst_rds", {17'd0, EXU_rd, MEM_rd, WB_rd}, 32'd0);
    check("arst_cnts", retire_cnt | stall_cnt, 32'd0);
    step();
    rst = 1'b0;
    drive(1'b1, 5'd22, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step(); idle();
    step();
    check("arst_wb_early", {31'd0, WB_valid}, 32'd0);
    step();
    check("arst_wb", {26'd0, WB_valid, WB_rd}, {26'd0, 1'b1, 5'd22});
    drain();
    check("arst_retire", retire_cnt, 32'd1);

    // retire counter wrap
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    drive(1'b1, 5'd23, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step(); idle();
    step(); step();
    check("wrap_pre", retire_cnt, 32'hFFFF_FFFF);
    step();
    check("wrap", retire_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
